// File: rtl/rtc_3wire_ctrl.sv
// rtc_3wire_ctrl: 3-wire serial RTC master issuing one command byte plus one data byte per transaction
module rtc_3wire_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       req,
  input  logic       rd,
  input  logic [5:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       rtc_reset_n,
  output logic       rtc_sclk,
  output logic       rtc_data_o,
  output logic       rtc_data_oe,
  input  logic       rtc_data_i
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, RECOVER} state_t;
  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d, nb;
  logic        half_q, half_d, rd_q, rd_d;
  logic [15:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d, rdata_q, rdata_d;
  logic        busy_q, busy_d, done_q, done_d, rst_n_q, rst_n_d;
  logic        sclk_q, sclk_d, dout_q, dout_d, oe_q, oe_d;
  logic        div_end;
  assign div_end     = div_q == 8'(CLK_DIV - 1);
  assign nb          = bit_q + 4'd1;
  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rtc_reset_n = rst_n_q;
  assign rtc_sclk    = sclk_q;
  assign rtc_data_o  = dout_q;
  assign rtc_data_oe = oe_q;
  // next-state and registered-output logic; the divider restarts at every phase boundary
  always_comb begin
    state_d = state_q;
    div_d   = (state_q == IDLE || div_end) ? 8'd0 : div_q + 8'd1;
    bit_d   = bit_q;
    half_d  = half_q;
    rd_d    = rd_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rst_n_d = rst_n_q;
    sclk_d  = sclk_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = SETUP;
        rd_d    = rd;
        tx_d    = {wdata, 1'b1, addr, rd};
        busy_d  = 1'b1;
        rst_n_d = 1'b1;
        oe_d    = 1'b1;
        dout_d  = rd;
      end
      SETUP: if (div_end) begin
        state_d = SHIFT;
        half_d  = 1'b0;
        bit_d   = 4'd0;
      end
      SHIFT: if (div_end) begin
        half_d = !half_q;
        sclk_d = !half_q;
        if (!half_q) begin
          if (rd_q && bit_q[3]) rx_d[bit_q[2:0]] = rtc_data_i;
        end else if (bit_q == 4'd15) begin
          state_d = HOLD;
        end else begin
          bit_d  = nb;
          oe_d   = oe_q && !(rd_q && nb[3]);
          dout_d = tx_q[nb] && !(rd_q && nb[3]);
        end
      end
      HOLD: if (div_end) begin
        state_d = RECOVER;
        done_d  = 1'b1;
        rst_n_d = 1'b0;
        oe_d    = 1'b0;
        dout_d  = 1'b0;
        rdata_d = rd_q ? rx_q : rdata_q;
      end
      RECOVER: if (div_end) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers, cleared asynchronously so a reset aborts any transfer
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      half_q  <= 1'b0;
      rd_q    <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rst_n_q <= 1'b0;
      sclk_q  <= 1'b0;
      dout_q  <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      rd_q    <= rd_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rst_n_q <= rst_n_d;
      sclk_q  <= sclk_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
    end
  end
endmodule

// File: tb/tb_rtc_3wire_ctrl.sv
// tb_rtc_3wire_ctrl: directed vector bench for rtc_3wire_ctrl at CLK_DIV 4 and 2
module tb_rtc_3wire_ctrl;
  logic sysclk = 0, reset = 1, req_a = 0, req_b = 0, rd = 0;
  logic [5:0] addr = 0;
  logic [7:0] wdata = 0, rtc_byte = 0;
  logic [7:0] rdata_a, rdata_b;
  logic busy_a, done_a, rstn_a, sclk_a, dout_a, oe_a, din_a;
  logic busy_b, done_b, rstn_b, sclk_b, dout_b, oe_b;
  logic [15:0] sda_a, sda_b;
  int edges_a = 0;
  int n_chk = 0, n_fail = 0;
  bit sel = 0;
  logic c_busy, c_done, c_rstn, c_sclk, c_oe;
  logic [7:0] c_rdata;
  logic [15:0] c_sda;

  always #5 sysclk = ~sysclk;

  rtc_3wire_ctrl #(.CLK_DIV(4)) dut_a (
    .sysclk(sysclk), .reset(reset), .req(req_a), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .busy(busy_a), .done(done_a), .rtc_reset_n(rstn_a), .rtc_sclk(sclk_a),
    .rtc_data_o(dout_a), .rtc_data_oe(oe_a), .rtc_data_i(din_a));
  rtc_3wire_ctrl #(.CLK_DIV(2)) dut_b (
    .sysclk(sysclk), .reset(reset), .req(req_b), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .busy(busy_b), .done(done_b), .rtc_reset_n(rstn_b), .rtc_sclk(sclk_b),
    .rtc_data_o(dout_b), .rtc_data_oe(oe_b), .rtc_data_i(1'b0));

  // RTC model: after the 8 command rising edges it presents rtc_byte LSB first
  always @(posedge sclk_a or negedge rstn_a)
    if (!rstn_a) edges_a <= 0;
    else edges_a <= edges_a + 1;
  assign din_a = (edges_a >= 8 && edges_a < 16) ? rtc_byte[3'(edges_a - 8)] : 1'b0;

  // line sampled by the RTC on each rising serial clock, LSB first into bit 0
  always @(posedge sclk_a) sda_a <= {dout_a, sda_a[15:1]};
  always @(posedge sclk_b) sda_b <= {dout_b, sda_b[15:1]};

  assign c_busy  = sel ? busy_b  : busy_a;
  assign c_done  = sel ? done_b  : done_a;
  assign c_rstn  = sel ? rstn_b  : rstn_a;
  assign c_sclk  = sel ? sclk_b  : sclk_a;
  assign c_oe    = sel ? oe_b    : oe_a;
  assign c_rdata = sel ? rdata_b : rdata_a;
  assign c_sda   = sel ? sda_b   : sda_a;

  typedef struct {
    bit sel; bit rd; logic [5:0] addr; logic [7:0] wdata; logic [7:0] rtc;
    logic [15:0] sda; logic [15:0] mask; logic [7:0] rdat;
    int done_at; int busy_at; int oe_off; int pulse_at;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, d_at, oe_off, dones, rises, bad, oe_bad, last_t, dv;
    logic last_s;
    logic [7:0] rd_done;
    dv = v.sel ? 2 : 4;
    sel = v.sel;
    @(negedge sysclk);
    rd = v.rd; addr = v.addr; wdata = v.wdata; rtc_byte = v.rtc;
    if (v.sel) req_b = 1; else req_a = 1;
    @(posedge sysclk); #1;
    req_a = 0; req_b = 0;
    chk($sformatf("v%0d busy_rstn_at_e0", idx), {30'd0, c_busy, c_rstn}, 32'd3);
    cyc = 0; d_at = -1; oe_off = -1; dones = 0; rises = 0; bad = 0; oe_bad = 0;
    last_t = 0; last_s = 0; rd_done = 0;
    while (c_busy && cyc < 400) begin
      if (v.pulse_at >= 0) req_a = (cyc == v.pulse_at);
      @(posedge sysclk); cyc++; #1;
      if (c_sclk !== last_s) begin
        if (c_sclk) begin
          rises++;
          if (rises > 1 && cyc - last_t != dv) bad++;
        end else if (cyc - last_t != dv) bad++;
        last_t = cyc; last_s = c_sclk;
      end
      if (c_done) begin
        dones++;
        if (d_at < 0) begin d_at = cyc; rd_done = c_rdata; end
      end
      if (!c_oe && oe_off < 0) oe_off = cyc;
      if (c_oe && oe_off >= 0) oe_bad++;
    end
    req_a = 0;
    chk($sformatf("v%0d done_at", idx), d_at, v.done_at);
    chk($sformatf("v%0d busy_drop_at", idx), cyc, v.busy_at);
    chk($sformatf("v%0d done_pulses", idx), dones, 1);
    chk($sformatf("v%0d sclk_rises", idx), rises, 16);
    chk($sformatf("v%0d sclk_half_errs", idx), bad, 0);
    chk($sformatf("v%0d oe_off_at", idx), oe_off, v.oe_off);
    chk($sformatf("v%0d oe_reasserted", idx), oe_bad, 0);
    chk($sformatf("v%0d rdata_at_done", idx), 32'(rd_done), 32'(v.rdat));
    chk($sformatf("v%0d sda_bits", idx), 32'(c_sda & v.mask), 32'(v.sda & v.mask));
    repeat (5) @(posedge sysclk);
    #1 chk($sformatf("v%0d idle_after", idx), {30'd0, c_busy, c_rstn}, 32'd0);
  endtask

  initial begin
    int cyc, d1, d2, e2, low_n, idle_n;
    vecs[0] = '{0, 0, 6'h00, 8'h59, 8'h00, 16'h5980, 16'hFFFF, 8'h00, 136, 140, 136, -1};
    vecs[1] = '{0, 1, 6'h01, 8'h00, 8'hA5, 16'h0083, 16'h00FF, 8'hA5, 136, 140, 68, -1};
    vecs[2] = '{0, 0, 6'h3F, 8'hC3, 8'h00, 16'hC3FE, 16'hFFFF, 8'hA5, 136, 140, 136, 50};
    vecs[3] = '{0, 1, 6'h2A, 8'h00, 8'h3C, 16'h00D5, 16'h00FF, 8'h3C, 136, 140, 68, -1};
    vecs[4] = '{1, 0, 6'h05, 8'hA6, 8'h00, 16'hA68A, 16'hFFFF, 8'h00, 68, 70, 68, -1};
    #1;
    chk("reset_outputs_a", {rdata_a, busy_a, done_a, rstn_a, sclk_a, dout_a, oe_a}, 32'd0);
    repeat (3) @(posedge sysclk);
    #1 chk("reset_outputs_b", {rdata_b, busy_b, done_b, rstn_b, sclk_b, dout_b, oe_b}, 32'd0);
    @(negedge sysclk) reset = 0;
    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);
    // back-to-back with req held high
    sel = 0;
    @(negedge sysclk);
    rd = 0; addr = 6'h12; wdata = 8'h3C; req_a = 1;
    @(posedge sysclk); #1;
    cyc = 0; d1 = -1; d2 = -1; e2 = -1; low_n = 0; idle_n = 0;
    while (d2 < 0 && cyc < 400) begin
      @(posedge sysclk); cyc++; #1;
      if (done_a) begin if (d1 < 0) d1 = cyc; else d2 = cyc; end
      if (d1 >= 0 && e2 < 0 && !rstn_a) low_n++;
      if (!busy_a) idle_n++;
      if (idle_n > 0 && busy_a && e2 < 0) e2 = cyc;
    end
    req_a = 0;
    chk("b2b_done1", d1, 136);
    chk("b2b_second_e0", e2, 141);
    chk("b2b_done2", d2, 277);
    chk("b2b_idle_cycles", idle_n, 1);
    chk("b2b_rstn_low_ge4", {31'd0, low_n >= 4}, 32'd1);
    cyc = 0;
    while (busy_a && cyc < 20) begin @(posedge sysclk); cyc++; end
    // reset abort of a read in progress
    @(negedge sysclk);
    rd = 1; addr = 6'h01; rtc_byte = 8'hA5; req_a = 1;
    @(posedge sysclk); #1 req_a = 0;
    repeat (70) @(posedge sysclk);
    #1 chk("abort_busy_before", {31'd0, busy_a}, 32'd1);
    reset = 1;
    #1 chk("abort_outputs", {rdata_a, busy_a, done_a, rstn_a, sclk_a, dout_a, oe_a}, 32'd0);
    d1 = 0;
    repeat (4) begin @(posedge sysclk); #1 if (done_a) d1++; end
    chk("abort_no_done", d1, 0);
    @(negedge sysclk);
    reset = 0; rd = 0; addr = 6'h00; wdata = 8'h59; req_a = 1;
    @(posedge sysclk); #1 req_a = 0;
    chk("first_req_after_reset", {30'd0, busy_a, rstn_a}, 32'd3);
    chk("abort_rdata_zero", 32'(rdata_a), 32'd0);
    cyc = 0; d1 = -1;
    while (busy_a && cyc < 200) begin
      @(posedge sysclk); cyc++; #1;
      if (done_a && d1 < 0) d1 = cyc;
    end
    chk("post_abort_done_at", d1, 136);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rtc_3wire_ctrl.md
RTC_3WIRE_CTRL -- requirements
Module: rtc_3wire_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning sysclk cycles per rtc_sclk half-period (legal range 2..255).
REQ-002 The block SHALL have port sysclk, input, 1, the single clock for all sequential logic.
REQ-003 The block SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port req, input, 1, a transaction request sampled only in IDLE.
REQ-005 The block SHALL have port rd, input, 1: 1 = read, 0 = write; latched with req.
REQ-006 The block SHALL have port addr, input, 6, the RAM/CK select bit plus a 5-bit register address; latched with req.
REQ-007 The block SHALL have port wdata, input, 8, the write byte; latched with req.
REQ-008 The block SHALL have port rdata, output, 8, the read byte; it holds its value until the next read completes.
REQ-009 The block SHALL have port busy, output, 1, high from req acceptance through the end of RECOVER.
REQ-010 The block SHALL have port done, output, 1, a single-cycle completion pulse.
REQ-011 The block SHALL have port rtc_reset_n, output, 1, the RTC chip enable (high = active).
REQ-012 The block SHALL have port rtc_sclk, output, 1, the RTC serial clock.
REQ-013 The block SHALL have ports rtc_data_o (output, 1), rtc_data_oe (output, 1) and rtc_data_i (input, 1); the top level builds the rtc_data_io tristate from these.

Function
REQ-014 States SHALL be IDLE, SETUP, SHIFT, HOLD and RECOVER.
REQ-015 In IDLE with req=1, the block SHALL latch rd, addr and wdata, set busy=1 and rtc_reset_n=1 on that edge (E0), and enter SETUP.
REQ-016 req SHALL be ignored in any state other than IDLE; no request is queued.
REQ-017 The command byte SHALL be {1, addr[5:0], rd}, shifted LSB first (rd bit first).
REQ-018 SETUP SHALL last CLK_DIV cycles with rtc_sclk=0, rtc_data_oe=1 and rtc_data_o = command bit 0.
REQ-019 SHIFT SHALL transfer 16 bit-slots; each slot is a low half of CLK_DIV cycles followed by a high half of CLK_DIV cycles on rtc_sclk.
REQ-020 In every driven slot, rtc_data_o SHALL change only at the start of the low half and stay stable through the rising edge.
REQ-021 Slots 0-7 SHALL drive the command byte; on a write, slots 8-15 SHALL drive wdata LSB first with rtc_data_oe=1 throughout.
REQ-022 On a read, rtc_data_oe SHALL go to 0 at the start of the slot-8 low half and stay 0 until IDLE.
REQ-023 On a read, rdata[k] SHALL be sampled from rtc_data_i on the last sysclk of the slot-(8+k) low half.
REQ-024 rdata SHALL update as a whole byte at the HOLD-to-RECOVER transition, not bit by bit.
REQ-025 HOLD SHALL last CLK_DIV cycles with rtc_sclk=0.
REQ-026 At the end of HOLD the block SHALL set rtc_reset_n=0, rtc_data_oe=0 and done=1 for exactly one cycle, at E0+34*CLK_DIV.
REQ-027 RECOVER SHALL hold rtc_reset_n low for CLK_DIV cycles, then return to IDLE with busy=0 at E0+35*CLK_DIV.
REQ-028 A req held high continuously SHALL start a new transaction on the first IDLE cycle after RECOVER.
REQ-029 The divider and bit counters SHALL wrap exactly at CLK_DIV-1 and 15; no extra slots are allowed.

Reset
REQ-030 While reset=1, and asynchronously on its assertion, the block SHALL hold state=IDLE, busy=0, done=0, rdata=0, rtc_reset_n=0, rtc_sclk=0, rtc_data_o=0 and rtc_data_oe=0.
REQ-031 Reset asserted mid-transaction SHALL abort the transaction with no done pulse and leave rdata=0.
REQ-032 The first request after reset deassertion SHALL be accepted on the first rising edge on which req=1.

Verification
REQ-033 Write test: CLK_DIV=4, addr=6'h00, wdata=8'h59, rd=0 -> SDA bits on 16 rising edges = command 8'h80 then 8'h59, both LSB first; done at E0+136; busy drops at E0+140.
REQ-034 Read test: addr=6'h01, rd=1, RTC model returns 8'hA5 -> command byte 8'h83; rtc_data_oe=0 from slot 8; rdata=8'hA5 when done pulses.
REQ-035 Busy-ignore test: pulse req at E0+50 during a transaction -> no effect; exactly one done pulse.
REQ-036 Back-to-back test: hold req=1 through two transactions -> rtc_reset_n low for at least 4 cycles between them; second E0 falls on the first IDLE cycle.
REQ-037 Reset-abort test: assert reset at E0+70 -> all outputs go to reset values in the same cycle; no done pulse; rdata=0.
REQ-038 Divider test: CLK_DIV=2 -> rtc_sclk high and low halves each measure exactly 2 cycles; done at E0+68.
